// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned ITER_CNT = 32;
    localparam int unsigned CNT_W    = 5;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response channel between the execute stage and the mul/div unit.
interface muldiv_unit_if;
    import muldiv_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [XLEN-1:0]   in_a;
    logic [XLEN-1:0]   in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              kill;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, kill, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, kill, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps on operand magnitudes,
// sign fix-up on the last step, div-by-zero / overflow resolved at accept.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] neg_x(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [TAG_W-1:0]    tag_q;
    logic                neg_q;
    logic [XLEN-1:0]     opb_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     result_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic                a_neg, b_neg, neg_d, special_d;
    logic [XLEN-1:0]     a_mag, b_mag, special_res_d;
    logic [XLEN:0]       mul_sum;
    logic [XLEN+1:0]     div_trial;
    logic [2*XLEN-1:0]   step_d, prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, result_d;
    logic                unused_trial_bit;

    // Accept-side decode: operand magnitudes, result sign, special cases
    always_comb begin
        logic a_signed, b_signed, is_div, div_zero, sig_ovf;
        a_signed = (bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU) ||
                   (bus.in_op == OP_DIV)  || (bus.in_op == OP_REM);
        b_signed = (bus.in_op == OP_MULH) || (bus.in_op == OP_DIV) ||
                   (bus.in_op == OP_REM);
        a_neg    = a_signed && bus.in_a[XLEN-1];
        b_neg    = b_signed && bus.in_b[XLEN-1];
        a_mag    = a_neg ? neg_w(bus.in_a) : bus.in_a;
        b_mag    = b_neg ? neg_w(bus.in_b) : bus.in_b;
        neg_d    = (bus.in_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        is_div   = bus.in_op[2];
        div_zero = is_div && (bus.in_b == '0);
        sig_ovf  = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) &&
                   (bus.in_a == INT_MIN) && (bus.in_b == '1);
        special_d     = div_zero || sig_ovf;
        special_res_d = '1;
        if (div_zero) begin
            special_res_d = bus.in_op[1] ? bus.in_a : '1;
        end else if (sig_ovf) begin
            special_res_d = bus.in_op[1] ? '0 : INT_MIN;
        end
    end

    // One shift-add or restoring-divide step, plus final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        div_trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
        unused_trial_bit = div_trial[XLEN];
        if (op_q[2]) begin
            if (!div_trial[XLEN+1]) begin
                step_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                step_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            step_d = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            step_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
        prod_fix = neg_q ? neg_x(step_d) : step_d;
        quo_fix  = neg_q ? neg_w(step_d[XLEN-1:0]) : step_d[XLEN-1:0];
        rem_fix  = neg_q ? neg_w(step_d[2*XLEN-1:XLEN]) : step_d[2*XLEN-1:XLEN];
        if (op_q == OP_MUL) begin
            result_d = prod_fix[XLEN-1:0];
        end else if (!op_q[2]) begin
            result_d = prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            result_d = quo_fix;
        end else begin
            result_d = rem_fix;
        end
    end

    // Control FSM and datapath registers; kill beats both accept and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            neg_q       <= 1'b0;
            opb_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && !bus.kill) begin
                        op_q       <= bus.in_op;
                        tag_q      <= bus.in_tag;
                        neg_q      <= neg_d;
                        opb_q      <= b_mag;
                        acc_q      <= {{XLEN{1'b0}}, a_mag};
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (special_d) begin
                            result_q    <= special_res_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.kill) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        acc_q <= step_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
                            result_q    <= result_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.kill || bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t vecs[12];

    muldiv_unit_if bus_if ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Count edges until out_valid is seen, bounded
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!bus_if.out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check({name, "_ret_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({name, "_ret_ready"}, 32'(bus_if.in_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_op    = op;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        bus_if.in_tag   = tag;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_a     = ~a;
        bus_if.in_b     = ~b;
        bus_if.in_tag   = ~tag;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    edges;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        check({nm, "_ready"}, 32'(bus_if.in_ready), 32'd1);
        issue(v.op, v.a, v.b, v.tag);
        wait_valid(edges);
        check({nm, "_latency"}, 32'(edges), 32'(v.lat));
        check({nm, "_result"}, bus_if.out_result, v.exp);
        check({nm, "_tag"}, 32'(bus_if.out_tag), 32'(v.tag));
        handshake(nm);
    endtask

    task automatic no_resp(input string name);
        logic seen;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        n_checks = 0;
        n_errors = 0;
        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 32};
        vecs[1]  = '{OP_MULH,   32'h80000000,   32'h80000000, 5'd1,  32'h40000000, 32};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 32};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'd2,        5'd3,  32'hFFFFFFFF, 32};
        vecs[4]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFD, 32};
        vecs[5]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,        5'd5,  32'hFFFFFFFF, 32};
        vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,        5'd6,  32'd14,       32};
        vecs[7]  = '{OP_REMU,   32'd100,        32'd7,        5'd7,  32'd2,        32};
        vecs[8]  = '{OP_DIVU,   32'h12345678,   32'd0,        5'd8,  32'hFFFFFFFF, 0};
        vecs[9]  = '{OP_REM,    32'd5,          32'd0,        5'd10, 32'd5,        0};
        vecs[10] = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd11, 32'h80000000, 0};
        vecs[11] = '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 5'd12, 32'd0,        0};

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_op     = 3'd0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.in_tag    = '0;
        bus_if.kill      = 1'b0;
        bus_if.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_result", bus_if.out_result, 32'd0);
        check("rst_out_tag", 32'(bus_if.out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-pressure with a competing request held on the input
        issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd9);
        bus_if.in_valid = 1'b1;
        bus_if.in_op    = OP_DIVU;
        bus_if.in_a     = 32'd100;
        bus_if.in_b     = 32'd7;
        bus_if.in_tag   = 5'd3;
        wait_valid(edges);
        check("bp_latency", 32'(edges), 32'd32);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", bus_if.out_result, 32'hFFFFFFEB);
            check("bp_hold_tag", 32'(bus_if.out_tag), 32'd9);
            check("bp_hold_ready", 32'(bus_if.in_ready), 32'd0);
        end
        handshake("bp");
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check("bp_next_accepted", 32'(bus_if.in_ready), 32'd0);
        wait_valid(edges);
        check("bp_next_latency", 32'(edges), 32'd32);
        check("bp_next_result", bus_if.out_result, 32'd14);
        check("bp_next_tag", 32'(bus_if.out_tag), 32'd3);
        handshake("bp_next");

        // kill at step 10 of CALC
        issue(OP_DIVU, 32'd100, 32'd7, 5'd4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus_if.kill = 1'b1;
        @(posedge clk);
        #1;
        bus_if.kill = 1'b0;
        check("kill_calc_valid", 32'(bus_if.out_valid), 32'd0);
        check("kill_calc_ready", 32'(bus_if.in_ready), 32'd1);
        no_resp("kill_calc_no_resp");

        // kill in IDLE blocks a same-cycle request
        @(negedge clk);
        bus_if.kill     = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_op    = OP_DIVU;
        bus_if.in_a     = 32'd9;
        bus_if.in_b     = 32'd0;
        @(posedge clk);
        #1;
        bus_if.kill     = 1'b0;
        bus_if.in_valid = 1'b0;
        check("kill_idle_ready", 32'(bus_if.in_ready), 32'd1);
        no_resp("kill_idle_no_resp");

        // kill together with out_ready in DONE
        issue(OP_REMU, 32'd100, 32'd7, 5'd6);
        wait_valid(edges);
        check("kd_result", bus_if.out_result, 32'd2);
        @(negedge clk);
        bus_if.kill      = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.kill      = 1'b0;
        bus_if.out_ready = 1'b0;
        check("kd_valid", 32'(bus_if.out_valid), 32'd0);
        check("kd_ready", 32'(bus_if.in_ready), 32'd1);

        // Asynchronous reset mid-CALC
        issue(OP_MULH, 32'h80000000, 32'h80000000, 5'd17);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("arst_out_result", bus_if.out_result, 32'd0);
        check("arst_out_tag", 32'(bus_if.out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[4], 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide responder. Accepts one (a, b, op) request from the execute stage over a valid/ready handshake, computes it over multiple cycles, and returns the 32-bit result on a valid/ready response channel.
- Runs alongside the single-cycle ALU, which cannot absorb M-extension latency.
- Pipeline stalls while in_ready is low.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- TAG_W, 5, width of the opaque tag (destination register index) carried from request to response.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  input  XLEN  rs1 operand
- in_b  input  XLEN  rs2 operand
- in_tag  input  TAG_W  request tag
- kill  input  1  abort the in-flight operation (branch flush)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_result  output  XLEN  result
- out_tag  output  TAG_W  tag of the request that produced out_result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, out_valid=0, out_result=0, out_tag=0, in_ready=1. Reset mid-operation discards all work; no response is produced.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: an edge with in_valid && in_ready captures op, tag, and operands. Signed ops take absolute values and record result sign. Counter is cleared.
  - Special cases go IDLE->DONE directly, so out_valid is high the cycle after accept:
    - divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> in_a
    - signed overflow (in_a=0x80000000, in_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0
  - All other ops go to CALC.
- CALC: one radix-2 step per edge, 32 steps.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring divide with a 33-bit partial remainder.
  - On the edge with counter==31, apply sign fix-up (two's-complement negate when needed), register out_result, go to DONE.
  - out_valid rises exactly 32 edges after the accept edge.
- Signedness:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
  - MUL returns the low 32 bits; MULH* return the high 32 bits of the 64-bit product.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of a. Division truncates toward zero.
- DONE: out_result and out_tag are held stable while out_valid=1 and out_ready=0.
  - An edge with out_ready=1 returns to IDLE; in_ready is high the following cycle.
  - There is no same-cycle response-to-request bypass: a new request is accepted no earlier than one cycle after the response handshake.
- kill:
  - In CALC or DONE: next state is IDLE, out_valid falls, no response is produced.
  - In IDLE: no effect. A request presented in the same cycle as kill is not accepted; kill has priority.
- kill and out_ready both high in DONE: treat as kill; the outcome is identical (IDLE).
- Input operands may change after accept without affecting the result.
- Width rules: all arithmetic is modulo 2^32 on output. There is no overflow or exception flag.

Decomposition:
- Shared package muldiv_pkg holds:
  - op localparams OP_MUL..OP_REMU (3'b000..3'b111)
  - state encoding ST_IDLE / ST_CALC / ST_DONE
  - ITER_CNT=32
- No sub-module is required. The datapath (64-bit accumulator, 33-bit subtractor, negate logic) stays in muldiv_unit.
- The two's-complement negate helper is a function inside the module, not a separate block.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> out_result=0xFFFFFFEB. out_valid rises 32 edges after accept. tag 5'd9 returned.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU -> 2.
- DIVU a=0x12345678, b=0 -> 0xFFFFFFFF with out_valid one cycle after accept. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE.
  - out_result and out_tag stay constant; in_ready stays 0.
  - in_valid held high is ignored until one cycle after the out_ready handshake.
- Abort: kill at CALC step 10 -> no out_valid, in_ready=1 next cycle. Then rst_n pulsed low mid-CALC -> all outputs 0 immediately (asynchronous), and the next request completes correctly.
